// File: rtl/aes_key_schedule_pkg.sv
// rtl/aes_key_schedule_pkg.sv - AES-128 key schedule constants, FSM state type and S-box helper
package aes_pkg;

  localparam int         NR       = 10;
  localparam int         KEY_W    = 128;
  localparam logic [3:0] LAST_IDX = 4'(NR);

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  typedef enum logic [1:0] {IDLE, EXPAND, READY, SERVE} ks_state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Forward S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_schedule_step.sv
// rtl/aes_key_schedule_step.sv - combinational single AES-128 round-key expansion step
module aes_key_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0] prev_key_i,
  input  logic [7:0]       rcon_i,
  output logic [KEY_W-1:0] next_key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_rot;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key_i;

  // RotWord is folded into the byte order fed to the four S-boxes
  assign sub_rot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

  assign n0 = w0 ^ sub_rot ^ {rcon_i, 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - AES-128 round-key expander and sequencer; AES_KEY_SCHEDULE_ZEROIZE_EN adds zeroize
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  input  logic             mode,
  input  logic             start,
  input  logic             round_adv,
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  input  logic             zeroize,
`endif
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_idx,
  output logic             key_ready,
  output logic             busy,
  output logic             done
);

  ks_state_t        state_q, state_d;
  logic [KEY_W-1:0] mem_q [0:NR];
  logic [3:0]       i_q, i_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             key_ready_q, key_ready_d;
  logic             done_q, done_d;

  logic             mem_we, mem_clr;
  logic [3:0]       mem_waddr;
  logic [KEY_W-1:0] mem_wdata, step_key;

  aes_key_step u_step (
    .prev_key_i (mem_q[i_q - 4'd1]),
    .rcon_i     (RCON[i_q]),
    .next_key_o (step_key)
  );

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    key_ready_d = key_ready_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    mem_clr     = 1'b0;
    mem_waddr   = i_q;
    mem_wdata   = step_key;

    // A key load is accepted in every state and wins over start
    if (key_valid) begin
      state_d     = EXPAND;
      i_d         = 4'd1;
      key_ready_d = 1'b0;
      mem_we      = 1'b1;
      mem_waddr   = 4'd0;
      mem_wdata   = key_in;
    end else begin
      unique case (state_q)
        EXPAND: begin
          mem_we = 1'b1;
          if (i_q == LAST_IDX) begin
            state_d     = READY;
            key_ready_d = 1'b1;
          end else begin
            i_d = i_q + 4'd1;
          end
        end
        READY: begin
          if (start) begin
            state_d = SERVE;
            mode_d  = mode;
            idx_d   = mode ? LAST_IDX : 4'd0;
            cnt_d   = 4'd0;
          end
        end
        SERVE: begin
          if (round_adv) begin
            if (cnt_q == LAST_IDX) begin
              state_d = READY;
              done_d  = 1'b1;
              cnt_d   = 4'd0;
              idx_d   = mode_q ? LAST_IDX : 4'd0;
            end else begin
              cnt_d = cnt_q + 4'd1;
              idx_d = mode_q ? idx_q - 4'd1 : idx_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end

`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
    if (zeroize) begin
      state_d     = IDLE;
      i_d         = 4'd1;
      cnt_d       = 4'd0;
      idx_d       = 4'd0;
      key_ready_d = 1'b0;
      done_d      = 1'b0;
      mem_we      = 1'b0;
      mem_clr     = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= 4'd1;
      cnt_q       <= 4'd0;
      idx_q       <= 4'd0;
      mode_q      <= 1'b0;
      key_ready_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      key_ready_q <= key_ready_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= NR; k++) mem_q[k] <= '0;
    end else if (mem_clr) begin
      for (int k = 0; k <= NR; k++) mem_q[k] <= '0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign round_key = mem_q[idx_q];
  assign round_idx = idx_q;
  assign key_ready = key_ready_q;
  assign done      = done_q;
  assign busy      = (state_q == EXPAND) || (state_q == SERVE);

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - scoreboard bench for aes_key_schedule against a word-level FIPS-197 model
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         mode = 1'b0;
  logic         start = 1'b0;
  logic         round_adv = 1'b0;
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_ready, busy, done;

  always #5 clk = ~clk;

  aes_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .mode      (mode),
    .start     (start),
    .round_adv (round_adv),
`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .round_key (round_key),
    .round_idx (round_idx),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  exp_t         key_sb[$];
  int           done_sb[$];
  logic [7:0]   sbox_m [256];
  logic [127:0] model_rk [11];
  bit           last_m = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // S-box built by walking the multiplicative group with generator 3
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      q = q ^ (q[7] ? 8'h09 : 8'h00);
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_m[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_m[0] = 8'h63;
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   di;
    if (!rst) begin
      if (busy && key_ready) begin
        if (key_sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_serve_cycle: got idx %0d expected none", round_idx);
        end else begin
          e = key_sb.pop_front();
          check("round_key", round_key, e.key);
          check("round_idx", round_idx, e.idx);
        end
      end
      if (done) begin
        if (done_sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          di = done_sb.pop_front();
          check("done_idx", round_idx, di);
          check("done_key", round_key, model_rk[di]);
        end
      end
    end
  end

  task automatic pulse_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk) #1;
    key_valid = 1'b0;
    key_in    = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
  endtask

  task automatic wait_ready(input string name);
    int cnt;
    cnt = 0;
    while (!key_ready && cnt < 30) begin
      start = (cnt == 3);
      if (cnt == 5) check({name, "_busy"}, busy, 1'b1);
      @(posedge clk) #1;
      start = 1'b0;
      cnt++;
    end
    check(name, cnt, 10);
  endtask

  task automatic serve(input bit m, input int gap, input int stop_at);
    int   seq [11];
    int   p;
    int   guard;
    exp_t e;
    for (int k = 0; k < 11; k++) seq[k] = m ? 10 - k : k;
    mode  = m;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    p     = 0;
    guard = 0;
    while (p < 11 && guard < 300) begin
      mode  = 1'($urandom);
      e.key = model_rk[seq[p]];
      e.idx = 4'(seq[p]);
      key_sb.push_back(e);
      if (p == stop_at) begin
        @(negedge clk) #1;
        return;
      end
      round_adv = ($urandom_range(99) >= gap);
      if (round_adv) begin
        p++;
        if (p == 11) done_sb.push_back(m ? 10 : 0);
      end
      @(posedge clk) #1;
      round_adv = 1'b0;
      guard++;
    end
    check("serve_complete", p, 11);
    @(negedge clk) #1;
    check("ready_after_done", {busy, key_ready}, 2'b01);
    check("idx_after_done", round_idx, m ? 10 : 0);
    last_m = m;
  endtask

  initial begin
    init_sbox();
    #1 rst = 1'b1;
    #1;
    check("rst_round_key", round_key, 128'h0);
    check("rst_flags", {key_ready, busy, done, round_idx}, 7'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    pulse_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_ready("fips_latency");
    serve(1'b0, 0, 1);
    check("fips_mem1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    pulse_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("abort_clears_ready", {busy, key_ready}, 2'b10);
    wait_ready("reload_latency");
    serve(1'b0, 0, -1);
    serve(1'b1, 30, -1);
    serve(1'b1, 0, 0);
    check("fips_mem10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("dec_first_idx", round_idx, 10);

    pulse_key(128'h000102030405060708090a0b0c0d0e0f);
    repeat (4) @(posedge clk) #1;
    pulse_key(128'h000102030405060708090a0b0c0d0e0f);
    wait_ready("restart_latency");
    serve(1'b1, 0, 0);
    check("restart_mem10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    pulse_key(128'h000102030405060708090a0b0c0d0e0f);
    wait_ready("abort_latency");
    serve(1'b0, 40, -1);

    round_adv = 1'b1;
    repeat (3) @(posedge clk) #1;
    round_adv = 1'b0;
    check("adv_in_ready", {busy, round_idx}, {1'b0, (last_m ? 4'd10 : 4'd0)});

    for (int t = 0; t < 4; t++) begin
      pulse_key({$urandom, $urandom, $urandom, $urandom});
      wait_ready("rand_latency");
      serve(1'($urandom), $urandom_range(50), -1);
      serve(1'($urandom), $urandom_range(50), -1);
    end

    serve(1'b0, 20, 4);
    rst = 1'b1;
    #1;
    check("async_rst_key", round_key, 128'h0);
    check("async_rst_flags", {key_ready, busy, done, round_idx}, 7'h0);
    @(posedge clk) #1;
    rst   = 1'b0;
    mode  = 1'b0;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    check("start_after_rst", {key_ready, busy, round_idx}, 6'h0);
    check("key_after_rst", round_key, 128'h0);

`ifdef AES_KEY_SCHEDULE_ZEROIZE_EN
    pulse_key({$urandom, $urandom, $urandom, $urandom});
    wait_ready("zeroize_load_latency");
    zeroize = 1'b1;
    start   = 1'b1;
    @(posedge clk) #1;
    zeroize = 1'b0;
    start   = 1'b0;
    check("zeroize_key", round_key, 128'h0);
    check("zeroize_flags", {key_ready, busy, round_idx}, 6'h0);
    repeat (3) @(posedge clk) #1;
    check("zeroize_idle", {key_ready, busy}, 2'b00);
`endif

    repeat (2) @(posedge clk) #1;
    check("scoreboard_drain", key_sb.size() + done_sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Generates and serves the AES-128 round keys for the round datapath. On load, it expands a 128-bit cipher key into 11 round keys (one per cycle) and stores them locally. It then presents one round key per core request: ascending order for encrypt, descending order for decrypt. It sits between host key-load logic and the AES round core, and is the producer end of the round_key interface that the core consumes.

Parameters:
NR, 10, number of rounds; only 10 is supported, so storage depth is NR+1.
KEY_W, 128, key/round-key width; only 128 is supported.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
key_in  input  128  cipher key; sampled when key_valid=1
key_valid  input  1  one-cycle load pulse
mode  input  1  0=encrypt (keys 0..10), 1=decrypt (keys 10..0); sampled on start
start  input  1  one-cycle pulse; begins serving a key sequence
round_adv  input  1  one-cycle pulse; core has consumed the current key
round_key  output  128  current round key, driven to the core
round_idx  output  4  index of the key currently presented (0..10)
key_ready  output  1  expansion complete and keys valid
busy  output  1  high in EXPAND or SERVE
done  output  1  one-cycle pulse after the 11th key is consumed

Behaviour:
- Interface: one clock domain (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - State=IDLE.
  - key_ready=0, busy=0, done=0, round_idx=0, round_key=0.
  - All 11 storage entries cleared to 0.
- State machine: IDLE, EXPAND, READY, SERVE.
- IDLE:
  - key_valid: mem[0]<=key_in, exp counter i<=1, go to EXPAND.
  - start is ignored.
- EXPAND:
  - Each cycle: mem[i]<=step(mem[i-1], RCON[i]); i++.
  - After writing mem[10], go to READY and set key_ready=1 on that same edge.
  - Latency: key_ready rises exactly 10 clocks after the edge that samples key_valid.
  - key_valid during EXPAND restarts with the new key (mem[0] rewritten, i=1).
  - start during EXPAND is ignored.
- READY:
  - start: latch mode into mode_q; round_idx<=(mode?10:0); go to SERVE.
  - key_valid: key_ready<=0, reload, go to EXPAND.
  - key_valid and start in the same cycle: key_valid wins, start is dropped.
- SERVE:
  - round_key is always mem[round_idx] (combinational read of the registered index).
  - round_adv: count++, and round_idx moves by ±1 according to mode_q.
  - The new key is visible in the cycle after the round_adv edge.
  - On the 11th round_adv: done=1 for one cycle, round_idx<=(mode_q?10:0), return to READY.
  - round_idx never wraps or exceeds 0..10.
  - key_valid in SERVE aborts the sequence (no done pulse), clears key_ready, goes to EXPAND.
  - start in SERVE is ignored.
  - mode changes in SERVE are ignored.
- round_adv outside SERVE is ignored.
- busy = (state==EXPAND) || (state==SERVE).
- step(): standard FIPS-197 expansion:
  - w0'=w0^SubWord(RotWord(w3))^{RCON,24'h0}.
  - w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - w0 is bits [127:96].
- Byte order: bits [127:120] are byte 0, matching the core's state packing.
- Reset mid-operation: immediate return to the reset values; any in-progress expansion or serve is lost.

Optional Feature:
AES_KEY_SCHEDULE_ZEROIZE_EN
- Defined:
  - Adds input port zeroize (1 bit).
  - When asserted, on the next edge all 11 entries clear to 0, key_ready=0, round_idx=0, state=IDLE.
  - done is not pulsed.
  - zeroize has priority over key_valid and start in the same cycle.
- Undefined: the port is absent, and keys persist until reload or rst.

Decomposition:
- Package aes_pkg:
  - RCON[1:10] constant array (8'h01..8'h36).
  - NR=10 constant.
  - ks_state_t enum {IDLE, EXPAND, READY, SERVE}.
- Sub-module aes_key_step:
  - Combinational: one round-key step from (prev_key, rcon).
  - Contains four forward S-box lookups.
  - Instantiated once and reused iteratively in EXPAND.

Test Plan:
1. Load key 2b7e151628aed2a6abf7158809cf4f3c -> key_ready rises 10 clocks later; mem[1]=a0fafe1788542cb123a339392a6c7605; mem[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
2. mode=0, start, then 11 round_adv pulses -> round_idx 0..10 in order; keys match the FIPS-197 schedule; done pulses once after the 11th; state returns to READY.
3. mode=1, start -> first round_key=d014f9a8...0ca6 and round_idx=10; the 11th adv leaves round_key=2b7e...4f3c before done; round_idx never underflows.
4. key_valid with key 000102030405060708090a0b0c0d0e0f, then the same key re-pulsed at EXPAND cycle 5 -> key_ready still rises exactly 10 clocks after the second pulse; mem[10]=13111d7fe3944a17f307a78b4d2b30c5.
5. Assert rst mid-SERVE (round_idx=4) -> outputs return to 0 with no clock edge; key_ready=0; a start after reset is ignored.
6. With AES_KEY_SCHEDULE_ZEROIZE_EN: zeroize and start together in READY -> next cycle round_key=0, key_ready=0, IDLE; start is ignored and done is never pulsed.
